// File: rtl/ascon128_enc_sequencer.sv
// Load/run/output sequencer wrapped around the two-round-per-cycle Ascon-128 core.
// Buffers one key/nonce/AD/plaintext message, runs the core once, then returns ciphertext and tag.
module ascon128_enc_sequencer #(
    parameter int unsigned CORE_LAT = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [127:0] core_sk,
    output logic [127:0] core_n,
    output logic [63:0]  core_a,
    output logic [63:0]  core_p,
    output logic         core_rst,
    input  logic [63:0]  core_c,
    input  logic [127:0] core_t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_c,
    output logic [127:0] out_t,
    output logic         busy
);

    localparam int unsigned WCNT_W    = 4;
    localparam int unsigned RCNT_W    = 5;
    localparam int unsigned LAST_WORD = 11;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]        state, state_next;
    logic [WCNT_W-1:0] wcnt, wcnt_next;
    logic [RCNT_W-1:0] rcnt, rcnt_next;
    logic              out_valid_next;
    logic              accept;
    logic              capture;

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LOAD;
            wcnt      <= '0;
            rcnt      <= '0;
            in_ready  <= 1'b0;
            core_rst  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            wcnt      <= wcnt_next;
            rcnt      <= rcnt_next;
            in_ready  <= (state_next == S_LOAD);
            core_rst  <= (state_next != S_RUN);
            out_valid <= out_valid_next;
            busy      <= (state_next != S_LOAD);
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next     = state;
        wcnt_next      = wcnt;
        rcnt_next      = rcnt;
        out_valid_next = out_valid;
        accept         = 1'b0;
        capture        = 1'b0;
        unique case (state)
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (wcnt == WCNT_W'(LAST_WORD)) begin
                        wcnt_next  = '0;
                        rcnt_next  = '0;
                        state_next = S_RUN;
                    end else begin
                        wcnt_next = wcnt + WCNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                rcnt_next = rcnt + RCNT_W'(1);
                if (rcnt == RCNT_W'(CORE_LAT)) begin
                    capture        = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_valid && out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Message buffer (MSW first) and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            core_sk <= '0;
            core_n  <= '0;
            core_a  <= '0;
            core_p  <= '0;
            out_c   <= '0;
            out_t   <= '0;
        end else begin
            if (accept) begin
                unique case (wcnt)
                    4'd0:    core_sk[127:96] <= in_data;
                    4'd1:    core_sk[95:64]  <= in_data;
                    4'd2:    core_sk[63:32]  <= in_data;
                    4'd3:    core_sk[31:0]   <= in_data;
                    4'd4:    core_n[127:96]  <= in_data;
                    4'd5:    core_n[95:64]   <= in_data;
                    4'd6:    core_n[63:32]   <= in_data;
                    4'd7:    core_n[31:0]    <= in_data;
                    4'd8:    core_a[63:32]   <= in_data;
                    4'd9:    core_a[31:0]    <= in_data;
                    4'd10:   core_p[63:32]   <= in_data;
                    4'd11:   core_p[31:0]    <= in_data;
                    default: ;
                endcase
            end
            if (capture) begin
                out_c <= core_c;
                out_t <= core_t;
            end
        end
    end

endmodule

// File: doc/ascon128_enc_sequencer.md
# ascon128_enc_sequencer

Sequencer and I/O buffer wrapped around the two-round-per-cycle Ascon-128 single-block encryption core. It collects key, nonce, associated data and plaintext as 32-bit words over a valid/ready stream and holds them stable on the core's wide inputs. It releases the core from reset for exactly one run, then captures ciphertext and tag and returns them over a valid/ready output. Each message is one 64-bit AD block and one 64-bit plaintext block.

## Interface
- CORE_LAT, 25, clock edges from core reset release until the core's tag register is written; fixed by the core schedule.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- in_data  in  32  word stream, 12 words per message, MSW first: words 0-3 = SK[127:0], 4-7 = N[127:0], 8-9 = A[63:0], 10-11 = P[63:0].
- core_sk, core_n  out  128  key and nonce to core.
- core_a, core_p  out  64  AD and plaintext to core.
- core_rst  out  1  synchronous reset driven to core.
- core_c  in  64  core ciphertext.
- core_t  in  128  core tag.
- out_valid  in/out: out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_c  out  64  captured ciphertext.
- out_t  out  128  captured tag.
- busy  out  1  high in RUN and OUT.

## Operation
- States: LOAD, RUN, OUT. Reset enters LOAD.
- LOAD:
  - in_ready=1.
  - On each in_valid&&in_ready edge, in_data is written into the 32-bit slice selected by the 4-bit word counter wcnt, then wcnt increments.
  - On acceptance of word 11: wcnt wraps to 0, state goes to RUN, run counter rcnt=0, core_rst goes low on the same edge.
- RUN:
  - in_ready=0; core_rst=0.
  - rcnt increments every edge.
  - Data registers are not writable, so the core inputs are constant for the whole run.
  - On the edge with rcnt==CORE_LAT:
    - out_c<=core_c, out_t<=core_t;
    - out_valid<=1, core_rst<=1;
    - state to OUT.
- OUT:
  - core_rst=1; in_ready=0; in_valid is ignored.
  - out_valid, out_c and out_t are held until out_valid&&out_ready.
  - On that edge: out_valid<=0, state to LOAD.
- Data registers keep the previous message until they are overwritten word by word. A partially loaded message never reaches the core, because core_rst stays high in LOAD.
- Ciphertext and tag are passed through from the core with no arithmetic. Counter widths: wcnt 4 bits, rcnt 5 bits, sized to hold CORE_LAT.

## Timing
- Reset values:
  - state=LOAD, wcnt=0, rcnt=0;
  - core_rst=1, in_ready=1 (from the cycle after reset deasserts), out_valid=0;
  - out_c=0, out_t=0, core_sk/n/a/p=0, busy=0.
- While reset is high: in_ready=0, and no word is accepted.
- Edge E0 accepts word 11. The core sees reset low at edges E1..E26; core count 0..24 spans E1..E25, and the core writes T at E25.
- Capture happens at E26 (rcnt==25). out_valid is high from the cycle after E26, i.e. 26 cycles after the accepting edge.
- The core's extra count step at E26 is harmless: core_rst is high from E26 onward.
- Minimum message period: 12 load cycles + 26 run cycles + 1 output cycle = 39 cycles, with in_valid and out_ready held high.
- After the output handshake, in_ready is high in the next cycle. Words are never accepted in the same cycle as the output handshake.
- in_valid gaps in LOAD stall wcnt; they do not reset it.
- out_ready backpressure of any length is tolerated. Outputs stay bit-stable while out_valid=1.
- Reset mid-LOAD, mid-RUN or in OUT: immediate return to reset values. Any partial message is discarded, and the core is reset via core_rst=1.

## Test plan
- Single message, SK=000102…0F, N=101112…1F, A=0x3031323334353637, P=0x4041424344454647, in_valid held high, out_ready held high:
  - core inputs equal these exact values for all of RUN;
  - out_valid rises 26 cycles after word 11;
  - out_c and out_t match the golden Ascon-128 model;
  - out_valid is high for exactly 1 cycle.
- Random in_valid gaps (50%) during load:
  - identical out_c/out_t as the gap-free run;
  - wcnt stalls on gaps.
- out_ready held low for 40 cycles:
  - out_valid stays 1 and out_c/out_t stay stable;
  - in_ready stays 0;
  - the handshake completes on the first out_ready=1 edge.
- Three back-to-back messages with different P values:
  - results arrive in order;
  - the period is exactly 39 cycles;
  - core_rst is low for exactly 26 edges per message.
- Reset asserted at rcnt=10, then a fresh message is loaded:
  - after the reset, out_valid=0 and core_rst=1;
  - the next result is correct for the new message only.
- Reset asserted after 7 words, then a full 12-word message is loaded:
  - loading restarts at word 0;
  - the result matches the golden model for the full message.
